// File: rtl/multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// multdiv_sequencer
//
// Control stage between the execute stage and the iterative divider and
// multiplier. A single-cycle request latches the operands and selects an
// engine. The sequencer then pulses that engine's restart and waits for its
// ready flag. It returns one registered result, an exception flag and a
// one-cycle result-ready pulse. busy stalls the pipeline while an operation
// is in flight.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   ctrl_MULT, ctrl_DIV           request pulses (MULT wins if both are high)
//   data_operandA/B               operands, sampled on the request edge
//   data_result                   quotient or low 32 bits of the product
//   data_exception                exception, valid with data_resultRDY
//   data_resultRDY                one-cycle result-valid pulse
//   busy                          pipeline stall
//   eng_a, eng_b                  latched operands driven to both engines
//   div_rst, mult_rst             active-high engine restarts
//   div_/mult_result, _exception, _ready   engine status
// ---------------------------------------------------------------------------
module multdiv_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy,
    output logic [31:0] eng_a,
    output logic [31:0] eng_b,
    output logic        div_rst,
    output logic        mult_rst,
    input  logic [31:0] div_result,
    input  logic [31:0] mult_result,
    input  logic        div_exception,
    input  logic        mult_exception,
    input  logic        div_ready,
    input  logic        mult_ready
);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    // The last BUSY cycle that may still wait. The abort fires on the edge
    // that ends BUSY cycle TIMEOUT.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             op_div;
    logic [CNT_W-1:0] tmo_cnt;
    logic             req;
    logic             req_div;
    logic             sel_ready;
    logic             sel_exception;
    logic [31:0]      sel_result;

    assign req     = ctrl_MULT | ctrl_DIV;
    assign req_div = ctrl_DIV & ~ctrl_MULT;

    // Route the selected engine's status. A divide exception forces the
    // result to zero, so no stale quotient bits leak out with the exception.
    always_comb begin
        sel_ready     = mult_ready;
        sel_exception = mult_exception;
        sel_result    = mult_result;
        if (op_div) begin
            sel_ready     = div_ready;
            sel_exception = div_exception;
            sel_result    = div_exception ? 32'd0 : div_result;
        end
    end

    // A request in any state starts a fresh operation. This also aborts
    // whatever was in flight, and that aborted operation never produces a
    // result-ready pulse. The selected engine's restart is registered on the
    // request edge, so it is high for exactly the START cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            op_div         <= 1'b0;
            tmo_cnt        <= '0;
            eng_a          <= 32'd0;
            eng_b          <= 32'd0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
            div_rst        <= 1'b1;
            mult_rst       <= 1'b1;
        end else begin
            data_resultRDY <= 1'b0;
            if (req) begin
                eng_a    <= data_operandA;
                eng_b    <= data_operandB;
                op_div   <= req_div;
                div_rst  <= req_div;
                mult_rst <= ~req_div;
                tmo_cnt  <= '0;
                busy     <= 1'b1;
                state    <= START;
            end else begin
                case (state)
                    IDLE: begin
                        div_rst  <= 1'b0;
                        mult_rst <= 1'b0;
                    end
                    START: begin
                        div_rst  <= 1'b0;
                        mult_rst <= 1'b0;
                        tmo_cnt  <= '0;
                        state    <= BUSY;
                    end
                    BUSY: begin
                        if (sel_ready) begin
                            data_result    <= sel_result;
                            data_exception <= sel_exception;
                            data_resultRDY <= 1'b1;
                            state          <= DONE;
                        end else if (tmo_cnt == TMO_LAST) begin
                            data_result    <= 32'd0;
                            data_exception <= 1'b1;
                            data_resultRDY <= 1'b1;
                            state          <= DONE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multdiv_sequencer
//
// Directed and randomized bench for multdiv_sequencer. It contains simple
// behavioural engines with programmable latency. Expected results and the
// result-ready cycle come from a high-level reference model. Cycle k means
// the clock cycle that starts k-1 edges after the request edge.
// ---------------------------------------------------------------------------
module tb_multdiv_sequencer;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    logic [31:0] eng_a;
    logic [31:0] eng_b;
    logic        div_rst;
    logic        mult_rst;
    logic [31:0] div_result;
    logic [31:0] mult_result;
    logic        div_exception;
    logic        mult_exception;
    logic        div_ready = 1'b0;
    logic        mult_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Engine knobs, changed only while the sequencer is idle.
    int div_lat = 33;
    int mult_lat = 17;
    bit div_stuck = 1'b0;
    int div_cnt = 0;
    int mult_cnt = 0;

    int div_rst_pulses = 0;
    int mult_rst_pulses = 0;
    logic div_rst_prev = 1'b1;
    logic mult_rst_prev = 1'b1;

    multdiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .data_result(data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy(busy),
        .eng_a(eng_a),
        .eng_b(eng_b),
        .div_rst(div_rst),
        .mult_rst(mult_rst),
        .div_result(div_result),
        .mult_result(mult_result),
        .div_exception(div_exception),
        .mult_exception(mult_exception),
        .div_ready(div_ready),
        .mult_ready(mult_ready)
    );

    always #5 clk = ~clk;

    // Behavioural divider: a zero divisor raises an exception and returns
    // junk, which must never reach data_result.
    assign div_exception  = (eng_b == 32'd0);
    assign div_result     = (eng_b == 32'd0) ? 32'hDEAD
                            : 32'($signed(eng_a) / $signed(eng_b));
    assign mult_result    = eng_a * eng_b;
    assign mult_exception = 1'b0;

    // Each engine raises ready N cycles after its restart falls. Ready then
    // stays high until the next restart.
    always @(posedge clk) begin
        if (div_rst) begin
            div_cnt   <= 0;
            div_ready <= 1'b0;
        end else begin
            if (div_cnt < 1000) div_cnt <= div_cnt + 1;
            div_ready <= !div_stuck && (div_cnt + 1 >= div_lat);
        end
        if (mult_rst) begin
            mult_cnt   <= 0;
            mult_ready <= 1'b0;
        end else begin
            if (mult_cnt < 1000) mult_cnt <= mult_cnt + 1;
            mult_ready <= (mult_cnt + 1 >= mult_lat);
        end
    end

    // Count rising edges of each engine restart.
    always @(negedge clk) begin
        if (div_rst && !div_rst_prev) div_rst_pulses = div_rst_pulses + 1;
        if (mult_rst && !mult_rst_prev) mult_rst_pulses = mult_rst_pulses + 1;
        div_rst_prev  = div_rst;
        mult_rst_prev = mult_rst;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: {exception, result} for one operation.
    function automatic logic [32:0] refModel(input bit is_div, input logic [31:0] a,
                                             input logic [31:0] b, input bit stuck);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (stuck) return {1'b1, 32'd0};
        if (is_div) begin
            if (b == 32'd0) return {1'b1, 32'd0};
            return {1'b0, 32'(sa / sb)};
        end
        return {1'b0, a * b};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present a request for one cycle. Returns #1 after the request edge,
    // which is in cycle 1.
    task automatic applyStimulus(input logic m, input logic d,
                                 input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clk);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Wait (bounded) for result-ready. Check the cycle it appears in, the
    // payload, an unbroken busy, and a single-cycle pulse.
    task automatic awaitResult(input string tag, input int exp_cycle,
                               input logic [32:0] exp);
        int cyc = 1;
        int busy_gaps = 0;
        bit seen = 1'b0;
        while (cyc <= 60 && !seen) begin
            if (data_resultRDY) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_gaps++;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        checkOutput({tag, " rdy seen"}, 32'(seen), 32'd1);
        checkOutput({tag, " rdy cycle"}, 32'(cyc), 32'(exp_cycle));
        checkOutput({tag, " result"}, data_result, exp[31:0]);
        checkOutput({tag, " exception"}, 32'(data_exception), 32'(exp[32]));
        checkOutput({tag, " busy at rdy"}, 32'(busy), 32'd1);
        checkOutput({tag, " busy gaps"}, 32'(busy_gaps), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, " rdy single pulse"}, 32'(data_resultRDY), 32'd0);
        checkOutput({tag, " busy released"}, 32'(busy), 32'd0);
        checkOutput({tag, " result held"}, data_result, exp[31:0]);
    endtask

    task automatic runOp(input string tag, input bit is_div, input logic [31:0] a,
                         input logic [31:0] b, input int n);
        if (is_div) div_lat = n;
        else mult_lat = n;
        applyStimulus(!is_div, is_div, a, b);
        checkOutput({tag, " eng_a"}, eng_a, a);
        checkOutput({tag, " eng_b"}, eng_b, b);
        awaitResult(tag, div_stuck && is_div ? TIMEOUT + 2 : n + 3,
                    refModel(is_div, a, b, div_stuck && is_div));
    endtask

    initial begin
        int d0;
        int m0;
        int rdy_count;
        logic [31:0] a;
        logic [31:0] b;
        bit is_div;
        int n;

        $display("[TB] reset state");
        #12;
        checkOutput("reset result", data_result, 32'd0);
        checkOutput("reset exception", 32'(data_exception), 32'd0);
        checkOutput("reset rdy", 32'(data_resultRDY), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset eng_a", eng_a, 32'd0);
        checkOutput("reset eng_b", eng_b, 32'd0);
        checkOutput("reset div_rst", 32'(div_rst), 32'd1);
        checkOutput("reset mult_rst", 32'(mult_rst), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle div_rst", 32'(div_rst), 32'd0);
        checkOutput("idle mult_rst", 32'(mult_rst), 32'd0);

        $display("[TB] divide 100/7");
        runOp("div 100/7", 1'b1, 32'd100, 32'd7, 33);

        $display("[TB] divide by zero");
        runOp("div by zero", 1'b1, 32'hFFFFFF9C, 32'd0, 33);

        $display("[TB] multiply 6*-7");
        d0 = div_rst_pulses;
        runOp("mult 6*-7", 1'b0, 32'd6, 32'hFFFFFFF9, 17);
        checkOutput("mult no div_rst", 32'(div_rst_pulses - d0), 32'd0);

        $display("[TB] simultaneous request then abort by divide");
        d0 = div_rst_pulses;
        m0 = mult_rst_pulses;
        mult_lat = 17;
        div_lat = 33;
        applyStimulus(1'b1, 1'b1, 32'd11, 32'd13);
        rdy_count = 0;
        repeat (10) begin
            if (data_resultRDY) rdy_count++;
            @(posedge clk);
            #1;
        end
        checkOutput("both mult_rst pulse", 32'(mult_rst_pulses - m0), 32'd1);
        checkOutput("both no div_rst", 32'(div_rst_pulses - d0), 32'd0);
        checkOutput("both no early rdy", 32'(rdy_count), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'd1000, 32'hFFFFFFFD);
        awaitResult("abort div", 36, refModel(1'b1, 32'd1000, 32'hFFFFFFFD, 1'b0));
        checkOutput("abort div_rst pulse", 32'(div_rst_pulses - d0), 32'd1);
        checkOutput("abort mult_rst once", 32'(mult_rst_pulses - m0), 32'd1);

        $display("[TB] timeout");
        div_stuck = 1'b1;
        runOp("timeout", 1'b1, 32'd50, 32'd5, 33);
        div_stuck = 1'b0;

        $display("[TB] randomized operations");
        for (int i = 0; i < 8; i++) begin
            is_div = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (is_div && b == 32'hFFFFFFFF) b = 32'd3;
            if (is_div && (i % 4) == 3) b = 32'd0;
            n = int'($urandom_range(1, 35));
            runOp($sformatf("rand%0d", i), is_div, a, b, n);
        end

        $display("[TB] asynchronous reset mid-operation");
        div_lat = 33;
        applyStimulus(1'b0, 1'b1, 32'd77, 32'd7);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("midrst busy", 32'(busy), 32'd0);
        checkOutput("midrst result", data_result, 32'd0);
        checkOutput("midrst exception", 32'(data_exception), 32'd0);
        checkOutput("midrst eng_a", eng_a, 32'd0);
        checkOutput("midrst div_rst", 32'(div_rst), 32'd1);
        checkOutput("midrst mult_rst", 32'(mult_rst), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        rdy_count = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (data_resultRDY) rdy_count++;
        end
        checkOutput("midrst no spurious rdy", 32'(rdy_count), 32'd0);
        runOp("div 9/3", 1'b1, 32'd9, 32'd3, 33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
